// File: rtl/mcp3002_pkg.sv
// Shared types, widths and command decode for the MCP3002 ADC responder.
package mcp3002_pkg;

   localparam int unsigned DATA_WIDTH = 10;
   localparam int unsigned DIFF_WIDTH = DATA_WIDTH + 1;
   localparam int unsigned CNT_WIDTH  = 4;
   localparam int unsigned CFG_WIDTH  = 3;

   // conv_config bit positions
   localparam int unsigned CFG_SGL  = 2;
   localparam int unsigned CFG_ODD  = 1;
   localparam int unsigned CFG_MSBF = 0;

   // {sgl, odd} channel-select codes
   localparam logic [1:0] SEL_CH0           = 2'b10;
   localparam logic [1:0] SEL_CH1           = 2'b11;
   localparam logic [1:0] SEL_CH0_MINUS_CH1 = 2'b00;
   localparam logic [1:0] SEL_CH1_MINUS_CH0 = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_CONFIG,
      S_NULL,
      S_MSB,
      S_LSB,
      S_TRAIL
   } state_t;

   typedef logic [DATA_WIDTH-1:0] sample_t;

   // a - b, clamped to zero when the 11-bit result goes negative
   function automatic sample_t sat_diff(input sample_t a, input sample_t b);
      logic [DIFF_WIDTH-1:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[DIFF_WIDTH-1] ? '0 : d[DATA_WIDTH-1:0];
   endfunction

   function automatic sample_t select_sample(input logic [1:0] sel,
                                             input sample_t ch0,
                                             input sample_t ch1);
      sample_t s;
      case (sel)
         SEL_CH0:           s = ch0;
         SEL_CH1:           s = ch1;
         SEL_CH0_MINUS_CH1: s = sat_diff(ch0, ch1);
         default:           s = sat_diff(ch1, ch0);
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mcp3002_responder_if.sv
// SPI pin bundle between an ADC master and the MCP3002 responder.
interface mcp3002_responder_if;
   logic spi_clk;
   logic spi_cs;
   logic spi_din;
   logic spi_dout;
   logic spi_dout_oe;

   modport master (
      output spi_clk,
      output spi_cs,
      output spi_din,
      input  spi_dout,
      input  spi_dout_oe
   );

   modport slave (
      input  spi_clk,
      input  spi_cs,
      input  spi_din,
      output spi_dout,
      output spi_dout_oe
   );
endinterface

// File: rtl/mcp3002_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall pulses aligned to the
// synchronized level. Edges are suppressed until the chain holds real pin values.
module mcp3002_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic [STAGES-1:0] primed;

   // chain[0] is the newest sample; primed fills with ones as reset values flush out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain  <= {STAGES{RESET_VAL}};
         primed <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         chain  <= {chain[STAGES-2:0], raw};
         primed <= {primed[STAGES-2:0], 1'b1};
         rise   <= primed[STAGES-1] &  chain[STAGES-2] & ~chain[STAGES-1];
         fall   <= primed[STAGES-1] & ~chain[STAGES-2] &  chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];

endmodule

// File: rtl/mcp3002_responder.sv
// MCP3002 10-bit ADC emulator on the device side of an SPI link (modes 0,0 and 1,1).
// Commands are taken on SCLK rises, data is driven on SCLK falls, all oversampled by clk.
module mcp3002_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DATA_WIDTH  = mcp3002_pkg::DATA_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   mcp3002_responder_if.slave                  spi,
   input  logic [DATA_WIDTH-1:0]               ch0_data,
   input  logic [DATA_WIDTH-1:0]               ch1_data,
   output logic                                conv_strobe,
   output logic [mcp3002_pkg::CFG_WIDTH-1:0]   conv_config,
   output logic                                busy,
   output logic                                frame_done,
   output logic                                frame_error
);

   import mcp3002_pkg::*;

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic din, din_rise, din_fall;
   logic unused_sync;

   mcp3002_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk   (clk),
      .rst   (rst),
      .raw   (spi.spi_clk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   mcp3002_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst   (rst),
      .raw   (spi.spi_cs),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   mcp3002_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
      .clk   (clk),
      .rst   (rst),
      .raw   (spi.spi_din),
      .level (din),
      .rise  (din_rise),
      .fall  (din_fall)
   );

   assign unused_sync = ^{sclk_level, cs_level, din_rise, din_fall};

   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   sgl_q;
   logic                   odd_q;
   logic [DATA_WIDTH-1:0]  sample_q;
   logic                   complete;
   logic                   start_seen;
   logic                   dout_q;
   logic                   oe_q;

   assign spi.spi_dout    = dout_q;
   assign spi.spi_dout_oe = oe_q;

   // Frame FSM; a CS rise outranks any SCLK edge seen on the same clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         sgl_q       <= 1'b0;
         odd_q       <= 1'b0;
         sample_q    <= '0;
         complete    <= 1'b0;
         start_seen  <= 1'b0;
         dout_q      <= 1'b0;
         oe_q        <= 1'b0;
         conv_strobe <= 1'b0;
         conv_config <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         conv_strobe <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;

         if (state != S_IDLE && cs_rise) begin
            state       <= S_IDLE;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= complete;
            frame_error <= ~complete & start_seen;
         end else begin
            case (state)
               S_IDLE: begin
                  oe_q <= 1'b0;
                  if (cs_fall) begin
                     state      <= S_WAIT_START;
                     busy       <= 1'b1;
                     complete   <= 1'b0;
                     start_seen <= 1'b0;
                     cnt        <= '0;
                  end
               end

               S_WAIT_START: begin
                  if (sclk_rise && din) begin
                     state      <= S_CONFIG;
                     start_seen <= 1'b1;
                     cnt        <= '0;
                  end
               end

               S_CONFIG: begin
                  if (sclk_rise) begin
                     cnt <= cnt + CNT_WIDTH'(1);
                     if (cnt == CNT_WIDTH'(0)) begin
                        sgl_q <= din;
                     end else if (cnt == CNT_WIDTH'(1)) begin
                        odd_q <= din;
                     end else begin
                        conv_config[CFG_SGL]  <= sgl_q;
                        conv_config[CFG_ODD]  <= odd_q;
                        conv_config[CFG_MSBF] <= din;
                        sample_q    <= select_sample({sgl_q, odd_q}, ch0_data, ch1_data);
                        conv_strobe <= 1'b1;
                        state       <= S_NULL;
                     end
                  end
               end

               S_NULL: begin
                  if (sclk_fall) begin
                     oe_q   <= 1'b1;
                     dout_q <= 1'b0;
                     cnt    <= CNT_WIDTH'(DATA_WIDTH - 1);
                     state  <= S_MSB;
                  end
               end

               // B9 down to B0
               S_MSB: begin
                  if (sclk_fall) begin
                     dout_q <= sample_q[cnt];
                     if (cnt == CNT_WIDTH'(0)) begin
                        if (conv_config[CFG_MSBF]) begin
                           state    <= S_TRAIL;
                           complete <= 1'b1;
                        end else begin
                           state <= S_LSB;
                           cnt   <= CNT_WIDTH'(1);
                        end
                     end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                     end
                  end
               end

               // B1 up to B9, B0 is shared with the MSB-first pass
               S_LSB: begin
                  if (sclk_fall) begin
                     dout_q <= sample_q[cnt];
                     if (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state    <= S_TRAIL;
                        complete <= 1'b1;
                     end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                     end
                  end
               end

               S_TRAIL: begin
                  if (sclk_fall) begin
                     dout_q <= 1'b0;
                  end
               end

               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mcp3002_responder.sv
// Directed bench for mcp3002_responder: drives SPI frames as a master and
// compares the sampled MISO stream and status pulses against hand-derived values.
module tb_mcp3002_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] ch0 = '0;
   logic [9:0] ch1 = '0;
   logic       conv_strobe;
   logic [2:0] conv_config;
   logic       busy;
   logic       frame_done;
   logic       frame_error;

   mcp3002_responder_if bus ();

   mcp3002_responder #(.SYNC_STAGES(2), .DATA_WIDTH(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi         (bus),
      .ch0_data    (ch0),
      .ch1_data    (ch1),
      .conv_strobe (conv_strobe),
      .conv_config (conv_config),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_strobe = 0;
   int n_done   = 0;
   int n_err    = 0;

   always @(posedge clk) begin
      if (conv_strobe) n_strobe <= n_strobe + 1;
      if (frame_done)  n_done   <= n_done + 1;
      if (frame_error) n_err    <= n_err + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic half_period();
      repeat (15) @(negedge clk);
   endtask

   task automatic cs_low();
      @(negedge clk);
      bus.spi_cs = 1'b0;
      half_period();
   endtask

   task automatic cs_high();
      bus.spi_cs  = 1'b1;
      bus.spi_din = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // nclk SCLK periods; cmd is sent MSB-first from its low ncmd bits, zeros after.
   // MISO/OE are sampled just before each rise, first rise ends up in the highest bit.
   task automatic shift(input logic [15:0] cmd, input int ncmd, input int nclk,
                        input bit cpol, output logic [63:0] rx, output logic [63:0] oe);
      logic [15:0] c;
      c  = cmd << (16 - ncmd);
      rx = '0;
      oe = '0;
      for (int i = 0; i < nclk; i++) begin
         bus.spi_clk = 1'b0;
         bus.spi_din = c[15];
         c = c << 1;
         half_period();
         rx = {rx[62:0], bus.spi_dout};
         oe = {oe[62:0], bus.spi_dout_oe};
         bus.spi_clk = 1'b1;
         half_period();
      end
      if (!cpol) begin
         bus.spi_clk = 1'b0;
         half_period();
      end
   endtask

   logic [63:0] rx, oe;
   int s0, d0, e0;

   initial begin
      bus.spi_clk = 1'b0;
      bus.spi_cs  = 1'b1;
      bus.spi_din = 1'b0;
      repeat (4) @(negedge clk);

      // reset state
      check("rst_dout", 64'(bus.spi_dout), 64'h0);
      check("rst_oe", 64'(bus.spi_dout_oe), 64'h0);
      check("rst_flags", 64'({conv_strobe, busy, frame_done, frame_error}), 64'h0);
      check("rst_cfg", 64'(conv_config), 64'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // ch0, MSB-first, 16 SCLK, mode 0,0
      ch0 = 10'h2A5; ch1 = 10'h3C3;
      s0 = n_strobe; d0 = n_done; e0 = n_err;
      cs_low();
      check("t1_busy_hi", 64'(busy), 64'h1);
      shift(16'b1101, 4, 16, 1'b0, rx, oe);
      cs_high();
      check("t1_rx", rx, 64'h54A);
      check("t1_oe", oe, 64'hFFF);
      check("t1_cfg", 64'(conv_config), 64'h5);
      check("t1_strobes", 64'(n_strobe - s0), 64'h1);
      check("t1_done", 64'(n_done - d0), 64'h1);
      check("t1_err", 64'(n_err - e0), 64'h0);
      check("t1_idle", 64'({busy, bus.spi_dout_oe}), 64'h0);

      // ch1, LSB-first tail, 24 SCLK, mode 1,1
      ch1 = 10'h0F3;
      s0 = n_strobe; d0 = n_done;
      bus.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      cs_low();
      shift(16'b1110, 4, 24, 1'b1, rx, oe);
      cs_high();
      check("t2_rx", rx, 64'h01E73C);
      check("t2_oe", oe, 64'hFFFFF);
      check("t2_cfg", 64'(conv_config), 64'h6);
      check("t2_done", 64'(n_done - d0), 64'h1);
      bus.spi_clk = 1'b0;
      repeat (4) @(negedge clk);

      // differential, negative result saturates to zero
      ch0 = 10'd100; ch1 = 10'd300;
      cs_low();
      shift(16'b1001, 4, 16, 1'b0, rx, oe);
      cs_high();
      check("t3_ch0m1_rx", rx, 64'h0);
      check("t3_ch0m1_cfg", 64'(conv_config), 64'h1);

      // differential ch1-ch0 = 200
      cs_low();
      shift(16'b1011, 4, 16, 1'b0, rx, oe);
      cs_high();
      check("t3_ch1m0_rx", rx, 64'h190);
      check("t3_ch1m0_cfg", 64'(conv_config), 64'h3);

      // full-scale positive difference
      ch0 = 10'h3FF; ch1 = 10'h000;
      cs_low();
      shift(16'b1001, 4, 16, 1'b0, rx, oe);
      cs_high();
      check("t3_full_rx", rx, 64'h7FE);

      // leading zeros, sample change after the latch is not seen
      ch0 = 10'h155; ch1 = 10'h000;
      s0 = n_strobe; d0 = n_done;
      cs_low();
      shift(16'b0001101, 7, 7, 1'b0, rx, oe);
      check("t4_cmd_rx", rx, 64'h0);
      check("t4_strobe", 64'(n_strobe - s0), 64'h1);
      check("t4_busy", 64'(busy), 64'h1);
      ch0 = 10'h3FF;
      shift(16'h0, 0, 12, 1'b0, rx, oe);
      cs_high();
      check("t4_rx", rx, 64'h2AA);
      check("t4_oe", oe, 64'hFFF);
      check("t4_done", 64'(n_done - d0), 64'h1);

      // CS raised after 5 data bits
      ch0 = 10'h2A5;
      d0 = n_done; e0 = n_err;
      cs_low();
      shift(16'b1101, 4, 9, 1'b0, rx, oe);
      check("t5_oe_mid", 64'(bus.spi_dout_oe), 64'h1);
      cs_high();
      check("t5_err", 64'(n_err - e0), 64'h1);
      check("t5_done", 64'(n_done - d0), 64'h0);
      check("t5_oe_off", 64'(bus.spi_dout_oe), 64'h0);

      // CS raised before the start bit
      d0 = n_done; e0 = n_err;
      cs_low();
      shift(16'h0, 0, 2, 1'b0, rx, oe);
      check("t5b_busy", 64'(busy), 64'h1);
      cs_high();
      check("t5b_pulses", 64'({n_done - d0, n_err - e0}), 64'h0);
      check("t5b_busy_lo", 64'(busy), 64'h0);

      // reset mid-data with CS held low
      s0 = n_strobe; d0 = n_done; e0 = n_err;
      cs_low();
      shift(16'b1101, 4, 10, 1'b0, rx, oe);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_rst_oe", 64'({bus.spi_dout_oe, bus.spi_dout}), 64'h0);
      check("t6_rst_busy", 64'(busy), 64'h0);
      check("t6_rst_cfg", 64'(conv_config), 64'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      shift(16'b1101, 4, 20, 1'b0, rx, oe);
      check("t6_ignored_rx", rx, 64'h0);
      check("t6_ignored_oe", oe, 64'h0);
      check("t6_ignored_busy", 64'(busy), 64'h0);
      cs_high();
      check("t6_no_pulses", 64'({n_done - d0, n_err - e0}), 64'h0);
      check("t6_strobe", 64'(n_strobe - s0), 64'h1);

      // first frame after recovery
      d0 = n_done;
      cs_low();
      shift(16'b1101, 4, 16, 1'b0, rx, oe);
      cs_high();
      check("t6_next_rx", rx, 64'h54A);
      check("t6_next_done", 64'(n_done - d0), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
